span_raster: RTL and testbench
==============================

// Module: span_raster
// PURPOSE
// Successor to the per-pixel scanline plotter. Walks one horizontal span [x0..x1] on row y.
// Emits one pixel per accepted handshake, carrying NUM_CH linearly interpolated channels
// (ch0 = depth, ch1.. = colour or other attributes).
// Per-span step = one divide per channel. Per-pixel values come from fixed-point
// accumulation instead of a divide at every pixel.
// Adds reversed-span handling and valid/ready back-pressure toward the framebuffer or z-test stage.
// PARAMETERS
// COORD_W  11  x/y coordinate width (unsigned)
// CH_W     16  width of each interpolated channel (unsigned)
// NUM_CH   4   number of interpolated channels; ch0 is depth
// FRAC_W   8   fractional bits in step and accumulators
// PORTS
// clk       in   1              clock, rising edge
// reset     in   1              asynchronous, active-high reset
// start     in   1              begin span; sampled only in IDLE
// x0, x1    in   COORD_W        span endpoints, any order
// y         in   COORD_W        row, passed through to pix_y
// v0, v1    in   NUM_CH*CH_W    channel values at x0 and x1; ch k = bits [k*CH_W +: CH_W]
// busy      out  1              high from the start-accept cycle until done
// pix_valid out  1              pixel beat valid
// pix_ready in   1              downstream accepts beat
// pix_x     out  COORD_W        pixel x
// pix_y     out  COORD_W        pixel y
// pix_v     out  NUM_CH*CH_W    interpolated channels
// done      out  1              one-cycle pulse after the last beat is accepted
// BEHAVIOUR
// - Reset (async): state=IDLE; busy, pix_valid, done = 0; pix_x/pix_y/pix_v = 0; divider cleared.
// - Inputs are captured on the start-accept cycle.
//   - If x0 > x1, swap x0<->x1 and v0<->v1, so pixels always come out in ascending x.
// - States:
//   - IDLE: start -> SETUP.
//   - SETUP (1 cycle):
//     - len = xhi - xlo.
//     - If len == 0, load accumulators with vlo and go to RUN.
//     - Otherwise go to DIV with k = 0.
//   - DIV:
//     - Sequential divide of |vhi[k]-vlo[k]| << FRAC_W by len.
//     - Negate the quotient if vhi[k] < vlo[k].
//     - Store step[k] as signed, CH_W+FRAC_W+1 bits.
//     - On div_done: k++. After NUM_CH divides, load acc[k] = vlo[k] << FRAC_W and go to RUN.
//   - RUN: pix_valid = 1. Outputs: pix_x = cur_x, pix_v[k] = acc[k] >> FRAC_W (floor).
//     - On pix_valid & pix_ready:
//       - If cur_x == xhi, go to DONE.
//       - Otherwise cur_x++ and acc[k] += step[k].
//     - On the final pixel (cur_x == xhi) pix_v is forced to vhi exactly, so there is no endpoint drift.
//   - DONE: done = 1 for one cycle, busy = 0 -> IDLE.
// - Handshake:
//   - pix_valid stays high and pix_x/pix_y/pix_v stay stable until accepted. No beat is dropped or repeated.
//   - pix_valid never depends combinationally on pix_ready.
//   - With pix_ready held high: one pixel per cycle.
// - Latency, start to first pix_valid:
//   - len == 0: 2 cycles.
//   - Otherwise: 2 + NUM_CH*DIV_LAT cycles, with DIV_LAT = CH_W+FRAC_W+1 (fixed).
// - Span of N pixels with pix_ready=1 throughout: done pulses exactly N+1 cycles after the first pix_valid.
// - Arithmetic: accumulator values outside [0, 2^CH_W-1] are clamped on output; the accumulators themselves are not clamped.
// - start while busy: ignored, with no effect on the current span.
// - Back-to-back spans: start may be asserted in the cycle done pulses. It is accepted in the IDLE cycle that follows.
// - Reset mid-span or mid-divide: immediate abort to the reset state. No done pulse.
// STRUCTURE
// - Shared package raster_pkg:
//   - typedef span_state_t {IDLE, SETUP, DIV, RUN, DONE}
//   - localparam DIV_LAT
//   - fixed-point helper function clamp_ch()
// - Sub-module span_divider:
//   - unsigned restoring divider, one bit per cycle, fixed DIV_LAT latency
//   - start/done pulse interface
//   - parameters NUM_W = CH_W+FRAC_W, DEN_W = COORD_W
//   - shared across channels and reused sequentially
// TESTING
// 1. Even step: x0=10, x1=13, y=5, ch0 0->300.
//    -> x=10,11,12,13; ch0=0,100,200,300; pix_y=5 on every beat; one done pulse.
// 2. Single pixel: x0=x1=7, ch0=55.
//    -> one beat with ch0=55, pix_valid 2 cycles after start, no DIV cycles.
// 3. Reversed span: x0=20, x1=17, ch0 40->10.
//    -> x=17,18,19,20; ch0=10,20,30,40.
// 4. Fractional step: x 0..3, ch0 0->10 (FRAC_W=8).
//    -> ch0=0,3,6,10 (floor on interior pixels, exact endpoint).
// 5. Back-pressure: 8-pixel span with pix_ready low 3 cycles mid-span.
//    -> data held stable while stalled; 8 unique beats in order.
// 6. Reset asserted in RUN at pixel 2, then new start.
//    -> outputs 0 immediately, no done pulse; the new span completes correctly.

Source files
------------

// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
// Module  : raster_pkg
// Brief   : Shared span-raster types, divider latency and channel clamp helper.
// Revision: 1.0
// ============================================================================
package raster_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        DIV   = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } span_state_t;

    localparam int CH_W_DEF   = 16;
    localparam int FRAC_W_DEF = 8;
    localparam int DIV_LAT    = CH_W_DEF + FRAC_W_DEF + 1;

    // Saturates an integer-part accumulator value into [0, 2^ch_w-1].
    function automatic logic [63:0] clamp_ch(input logic signed [63:0] acc_int, input int ch_w);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< ch_w) - 64'sd1;
        if (acc_int < 64'sd0)
            return 64'd0;
        if (acc_int > max_v)
            return max_v;
        return acc_int;
    endfunction

endpackage
`default_nettype wire

// File: rtl/span_divider.sv
`default_nettype none
// ============================================================================
// Module  : span_divider
// Brief   : Unsigned restoring divider, one quotient bit per cycle, done NUM_W+1
//           cycles after start.
// Revision: 1.0
// ============================================================================
module span_divider #(
    parameter int NUM_W = 24,
    parameter int DEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic [NUM_W-1:0] quo,
    output logic             done
);
    localparam int c_CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0]   r_quo;
    logic [DEN_W-1:0]   r_rem;
    logic [DEN_W-1:0]   r_den;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [DEN_W:0]     w_rem_sh;
    logic [DEN_W:0]     w_rem_sub;
    logic               w_fits;

    // Remainder stays below den, so the restored value always fits DEN_W bits.
    always_comb begin
        w_rem_sh  = {r_rem, r_quo[NUM_W-1]};
        w_rem_sub = w_rem_sh - {1'b0, r_den};
        w_fits    = (w_rem_sh >= {1'b0, r_den});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_quo  <= num;
                r_rem  <= '0;
                r_den  <= den;
                r_cnt  <= c_CNT_W'(NUM_W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_quo <= {r_quo[NUM_W-2:0], w_fits};
                r_rem <= w_fits ? w_rem_sub[DEN_W-1:0] : w_rem_sh[DEN_W-1:0];
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == c_CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quo  = r_quo;
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/span_raster.sv
`default_nettype none
// ============================================================================
// Module  : span_raster
// Brief   : Walks one span [x0..x1] on row y, emitting one pixel per handshake
//           with NUM_CH channels interpolated by fixed-point accumulation.
// Revision: 1.0
// ============================================================================
module span_raster
    import raster_pkg::*;
#(
    parameter int COORD_W = 11,
    parameter int CH_W    = 16,
    parameter int NUM_CH  = 4,
    parameter int FRAC_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [COORD_W-1:0]       x0,
    input  logic [COORD_W-1:0]       x1,
    input  logic [COORD_W-1:0]       y,
    input  logic [NUM_CH*CH_W-1:0]   v0,
    input  logic [NUM_CH*CH_W-1:0]   v1,
    output logic                     busy,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [COORD_W-1:0]       pix_x,
    output logic [COORD_W-1:0]       pix_y,
    output logic [NUM_CH*CH_W-1:0]   pix_v,
    output logic                     done
);
    localparam int c_NUM_W  = CH_W + FRAC_W;
    localparam int c_STEP_W = c_NUM_W + 1;
    localparam int c_ACC_W  = c_NUM_W + 2;
    localparam int c_K_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    span_state_t                  r_state, w_state_nx;
    logic [COORD_W-1:0]           r_xlo, r_xhi, r_cur_x, r_y;
    logic [NUM_CH*CH_W-1:0]       r_vlo, r_vhi;
    logic [c_K_W-1:0]             r_k;
    logic                         r_done;
    logic signed [c_STEP_W-1:0]   r_step [NUM_CH];
    logic signed [c_ACC_W-1:0]    r_acc  [NUM_CH];

    logic [COORD_W-1:0]           w_len;
    logic                         w_at_end, w_last_k;
    logic [CH_W-1:0]              w_mag  [NUM_CH];
    logic                         w_neg  [NUM_CH];
    logic [c_K_W-1:0]             w_div_k;
    logic                         w_div_start, w_div_done;
    logic [c_NUM_W-1:0]           w_num, w_quo;

    assign w_len    = r_xhi - r_xlo;
    assign w_at_end = (r_cur_x == r_xhi);
    assign w_last_k = (r_k == c_K_W'(NUM_CH - 1));

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic [CH_W-1:0]                 w_lo, w_hi;
            logic signed [c_ACC_W-FRAC_W-1:0] w_int;
            assign w_lo     = r_vlo[g*CH_W +: CH_W];
            assign w_hi     = r_vhi[g*CH_W +: CH_W];
            assign w_neg[g] = (w_hi < w_lo);
            assign w_mag[g] = w_neg[g] ? (w_lo - w_hi) : (w_hi - w_lo);
            // Floor of the accumulator; the last pixel is pinned to the endpoint value.
            assign w_int    = $signed(r_acc[g][c_ACC_W-1:FRAC_W]);
            assign pix_v[g*CH_W +: CH_W] = ((r_state == RUN) && w_at_end) ? w_hi
                                         : CH_W'(clamp_ch(64'(w_int), CH_W));
        end
    endgenerate

    // The divider is relaunched in the same cycle the previous channel finishes.
    assign w_div_k     = (r_state == DIV) ? r_k + 1'b1 : '0;
    assign w_num       = {w_mag[w_div_k], {FRAC_W{1'b0}}};
    assign w_div_start = ((r_state == SETUP) && (w_len != '0)) ||
                         ((r_state == DIV) && w_div_done && !w_last_k);

    span_divider #(
        .NUM_W (c_NUM_W),
        .DEN_W (COORD_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (w_div_start),
        .num   (w_num),
        .den   (w_len),
        .quo   (w_quo),
        .done  (w_div_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        pix_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    busy       = 1'b1;
                    w_state_nx = SETUP;
                end
            end
            SETUP: begin
                busy       = 1'b1;
                w_state_nx = (w_len == '0) ? RUN : DIV;
            end
            DIV: begin
                busy = 1'b1;
                if (w_div_done && w_last_k)
                    w_state_nx = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
                if (pix_ready && w_at_end)
                    w_state_nx = DONE;
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xlo   <= '0;
            r_xhi   <= '0;
            r_cur_x <= '0;
            r_y     <= '0;
            r_vlo   <= '0;
            r_vhi   <= '0;
            r_k     <= '0;
            r_done  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_step[k] <= '0;
                r_acc[k]  <= '0;
            end
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_k <= '0;
                        r_y <= y;
                        if (x0 > x1) begin
                            r_xlo   <= x1;
                            r_xhi   <= x0;
                            r_cur_x <= x1;
                            r_vlo   <= v1;
                            r_vhi   <= v0;
                        end else begin
                            r_xlo   <= x0;
                            r_xhi   <= x1;
                            r_cur_x <= x0;
                            r_vlo   <= v0;
                            r_vhi   <= v1;
                        end
                    end
                end
                SETUP: begin
                    if (w_len == '0)
                        for (int k = 0; k < NUM_CH; k++)
                            r_acc[k] <= $signed({2'b00, r_vlo[k*CH_W +: CH_W], {FRAC_W{1'b0}}});
                end
                DIV: begin
                    if (w_div_done) begin
                        r_step[r_k] <= w_neg[r_k] ? -$signed({1'b0, w_quo}) : $signed({1'b0, w_quo});
                        r_k         <= r_k + 1'b1;
                        if (w_last_k)
                            for (int k = 0; k < NUM_CH; k++)
                                r_acc[k] <= $signed({2'b00, r_vlo[k*CH_W +: CH_W], {FRAC_W{1'b0}}});
                    end
                end
                RUN: begin
                    if (pix_ready && !w_at_end) begin
                        r_cur_x <= r_cur_x + 1'b1;
                        for (int k = 0; k < NUM_CH; k++)
                            r_acc[k] <= r_acc[k] + c_ACC_W'(r_step[k]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_x = r_cur_x;
    assign pix_y = r_y;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_span_raster.sv
`default_nettype none
// ============================================================================
// Module  : tb_span_raster
// Brief   : Directed self-checking bench for span_raster.
// Revision: 1.0
// ============================================================================
module tb_span_raster;
    import raster_pkg::*;

    logic        clk, reset, start, pix_ready;
    logic [10:0] x0, x1, y;
    logic [63:0] v0, v1;
    logic        busy, pix_valid, done;
    logic [10:0] pix_x, pix_y;
    logic [63:0] pix_v;

    int total = 0;
    int bad   = 0;

    logic [10:0] got_x [16];
    logic [10:0] got_y [16];
    logic [63:0] got_v [16];
    int nbeats, first_lat, done_lat, done_cnt, hold_err;
    int stall_at = -1, stall_len = 0, poke_at = -1;
    bit chain_next = 0;
    logic [10:0] nx0, nx1, ny;
    logic [63:0] nv0, nv1;

    span_raster dut (
        .clk(clk), .reset(reset), .start(start), .x0(x0), .x1(x1), .y(y),
        .v0(v0), .v1(v1), .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_v(pix_v), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Runs one span from the start-accept cycle (c=0) and records every accepted beat.
    task automatic run_span(input logic [10:0] a, input logic [10:0] b, input logic [10:0] yy,
                            input logic [63:0] va, input logic [63:0] vb, input bit pre_started);
        int c, stalled, after;
        bit fin, hold_valid;
        logic [10:0] hx, hy;
        logic [63:0] hv;
        for (int i = 0; i < 16; i++) begin
            got_x[i] = 'x; got_y[i] = 'x; got_v[i] = 'x;
        end
        nbeats = 0; first_lat = -1; done_lat = -1; done_cnt = 0; hold_err = 0;
        if (!pre_started) begin
            x0 = a; x1 = b; y = yy; v0 = va; v1 = vb; start = 1'b1;
        end
        c = 0; stalled = 0; after = 0; fin = 0; hold_valid = 0;
        hx = '0; hy = '0; hv = '0;
        pix_ready = 1'b1;
        while (!fin) begin
            @(posedge clk); #1;
            c++;
            if (c == poke_at) begin
                start = 1'b1; x0 = 11'd0; x1 = 11'd600; v0 = '1; v1 = '0;
            end else begin
                start = 1'b0;
            end
            if (pix_valid && first_lat < 0) first_lat = c;
            if (hold_valid && (!pix_valid || pix_x !== hx || pix_y !== hy || pix_v !== hv))
                hold_err++;
            pix_ready = !(stall_len > 0 && nbeats == stall_at && stalled < stall_len);
            if (pix_valid && !pix_ready) begin
                stalled++; hold_valid = 1; hx = pix_x; hy = pix_y; hv = pix_v;
            end else begin
                hold_valid = 0;
            end
            if (pix_valid && pix_ready) begin
                if (nbeats < 16) begin
                    got_x[nbeats] = pix_x; got_y[nbeats] = pix_y; got_v[nbeats] = pix_v;
                end
                nbeats++;
            end
            if (done) begin
                done_cnt++;
                if (done_lat < 0) done_lat = c;
            end
            if (done_lat >= 0) begin
                if (chain_next) begin
                    start = 1'b1; x0 = nx0; x1 = nx1; y = ny; v0 = nv0; v1 = nv1;
                    chain_next = 0; fin = 1;
                end else begin
                    after++;
                    if (after >= 3) fin = 1;
                end
            end
            if (c > 400) fin = 1;
        end
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
        x0 = '0; x1 = '0; y = '0; v0 = '0; v1 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", pix_valid); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if ({pix_x, pix_y} !== 22'd0) begin bad++; $display("FAIL reset_xy got=%0d/%0d want=0/0", pix_x, pix_y); end
        total++; if (pix_v !== 64'd0)    begin bad++; $display("FAIL reset_v got=%h want=0", pix_v); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (pix_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset got valid=%b busy=%b want 0/0", pix_valid, busy);
        end
    endtask

    task automatic test_even_step();
        int e0 [4] = '{0, 100, 200, 300};
        int e1 [4] = '{1000, 800, 600, 400};
        int e2 [4] = '{0, 0, 0, 1};
        poke_at = 50;
        run_span(11'd10, 11'd13, 11'd5, pk(0, 1000, 0, 65535), pk(300, 400, 1, 65535), 0);
        poke_at = -1;
        total++; if (nbeats !== 4) begin bad++; $display("FAIL even_nbeats got=%0d want=4", nbeats); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_x[i] !== 11'(10 + i) || got_y[i] !== 11'd5 || got_v[i] !== pk(e0[i], e1[i], e2[i], 65535)) begin
                bad++;
                $display("FAIL even_beat%0d got x=%0d y=%0d v=%h want x=%0d y=5 v=%h",
                         i, got_x[i], got_y[i], got_v[i], 10 + i, pk(e0[i], e1[i], e2[i], 65535));
            end
        end
        total++; if (first_lat !== 2 + 4 * DIV_LAT) begin bad++; $display("FAIL even_latency got=%0d want=%0d", first_lat, 2 + 4 * DIV_LAT); end
        total++; if (done_lat !== first_lat + 5 || done_cnt !== 1) begin
            bad++; $display("FAIL even_done got lat=%0d cnt=%0d want lat=%0d cnt=1", done_lat, done_cnt, first_lat + 5);
        end
    endtask

    task automatic test_single();
        run_span(11'd7, 11'd7, 11'd3, pk(55, 1, 2, 3), pk(55, 1, 2, 3), 0);
        total++; if (nbeats !== 1 || got_x[0] !== 11'd7 || got_v[0] !== pk(55, 1, 2, 3)) begin
            bad++; $display("FAIL single_beat got n=%0d x=%0d v=%h want n=1 x=7 v=%h", nbeats, got_x[0], got_v[0], pk(55, 1, 2, 3));
        end
        total++; if (first_lat !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", first_lat); end
        total++; if (done_lat !== 4 || done_cnt !== 1) begin
            bad++; $display("FAIL single_done got lat=%0d cnt=%0d want lat=4 cnt=1", done_lat, done_cnt);
        end
    endtask

    task automatic test_reversed();
        int e0 [4] = '{10, 20, 30, 40};
        int e1 [4] = '{90, 60, 30, 0};
        run_span(11'd20, 11'd17, 11'd8, pk(40, 0, 0, 0), pk(10, 90, 0, 0), 0);
        total++; if (nbeats !== 4) begin bad++; $display("FAIL rev_nbeats got=%0d want=4", nbeats); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_x[i] !== 11'(17 + i) || got_v[i] !== pk(e0[i], e1[i], 0, 0)) begin
                bad++;
                $display("FAIL rev_beat%0d got x=%0d v=%h want x=%0d v=%h", i, got_x[i], got_v[i], 17 + i, pk(e0[i], e1[i], 0, 0));
            end
        end
    endtask

    task automatic test_fractional();
        int e0 [4] = '{0, 3, 6, 10};
        int e1 [4] = '{10, 6, 3, 0};
        run_span(11'd0, 11'd3, 11'd1, pk(0, 10, 0, 0), pk(10, 0, 0, 0), 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_x[i] !== 11'(i) || got_v[i] !== pk(e0[i], e1[i], 0, 0)) begin
                bad++;
                $display("FAIL frac_beat%0d got x=%0d v=%h want x=%0d v=%h", i, got_x[i], got_v[i], i, pk(e0[i], e1[i], 0, 0));
            end
        end
    endtask

    task automatic test_backpressure();
        stall_at = 3; stall_len = 3;
        run_span(11'd100, 11'd107, 11'd9, pk(0, 700, 0, 0), pk(700, 0, 0, 0), 0);
        stall_at = -1; stall_len = 0;
        total++; if (nbeats !== 8) begin bad++; $display("FAIL bp_nbeats got=%0d want=8", nbeats); end
        total++; if (hold_err !== 0) begin bad++; $display("FAIL bp_hold got=%0d unstable cycles want=0", hold_err); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_x[i] !== 11'(100 + i) || got_y[i] !== 11'd9 || got_v[i] !== pk(100 * i, 700 - 100 * i, 0, 0)) begin
                bad++;
                $display("FAIL bp_beat%0d got x=%0d v=%h want x=%0d v=%h", i, got_x[i], got_v[i], 100 + i, pk(100 * i, 700 - 100 * i, 0, 0));
            end
        end
        total++; if (done_lat !== 2 + 4 * DIV_LAT + 8 + 1 + 3) begin
            bad++; $display("FAIL bp_done_lat got=%0d want=%0d", done_lat, 2 + 4 * DIV_LAT + 12);
        end
    endtask

    task automatic test_back_to_back();
        chain_next = 1;
        nx0 = 11'd5; nx1 = 11'd5; ny = 11'd4; nv0 = pk(77, 0, 0, 0); nv1 = pk(77, 0, 0, 0);
        run_span(11'd30, 11'd31, 11'd4, pk(0, 0, 0, 0), pk(2, 0, 0, 0), 0);
        total++; if (nbeats !== 2 || got_v[0] !== pk(0, 0, 0, 0) || got_v[1] !== pk(2, 0, 0, 0)) begin
            bad++; $display("FAIL b2b_first got n=%0d v0=%h v1=%h want n=2 0/2", nbeats, got_v[0], got_v[1]);
        end
        run_span(11'd0, 11'd0, 11'd0, 64'd0, 64'd0, 1);
        total++; if (nbeats !== 1 || got_x[0] !== 11'd5 || got_v[0] !== pk(77, 0, 0, 0) || first_lat !== 2) begin
            bad++; $display("FAIL b2b_second got n=%0d x=%0d v=%h lat=%0d want n=1 x=5 v=%h lat=2",
                            nbeats, got_x[0], got_v[0], first_lat, pk(77, 0, 0, 0));
        end
    endtask

    task automatic test_reset_midspan();
        int c, accepted, dn;
        x0 = 11'd0; x1 = 11'd5; y = 11'd2; v0 = pk(0, 0, 0, 0); v1 = pk(500, 0, 0, 0);
        start = 1'b1; pix_ready = 1'b1; accepted = 0; c = 0;
        while (accepted < 2 && c < 300) begin
            @(posedge clk); #1;
            c++; start = 1'b0;
            if (pix_valid && pix_ready) accepted++;
        end
        @(posedge clk); #1;
        total++; if (pix_valid !== 1'b1 || pix_x !== 11'd2 || pix_v !== pk(200, 0, 0, 0)) begin
            bad++; $display("FAIL rst_mid_pixel2 got valid=%b x=%0d v=%h want 1/2/%h", pix_valid, pix_x, pix_v, pk(200, 0, 0, 0));
        end
        #2 reset = 1'b1;
        #1;
        total++; if (pix_valid !== 1'b0 || busy !== 1'b0 || pix_x !== 11'd0 || pix_y !== 11'd0 || pix_v !== 64'd0) begin
            bad++; $display("FAIL rst_mid_outputs got valid=%b busy=%b x=%0d y=%0d v=%h want all 0", pix_valid, busy, pix_x, pix_y, pix_v);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        dn = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        total++; if (dn !== 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_nodone got done=%0d busy=%b want 0/0", dn, busy); end
        run_span(11'd40, 11'd42, 11'd6, pk(0, 0, 0, 0), pk(20, 0, 0, 0), 0);
        total++; if (nbeats !== 3 || got_v[0] !== pk(0, 0, 0, 0) || got_v[1] !== pk(10, 0, 0, 0) ||
                     got_v[2] !== pk(20, 0, 0, 0) || got_x[2] !== 11'd42 || done_cnt !== 1) begin
            bad++; $display("FAIL rst_mid_newspan got n=%0d v=%h/%h/%h x2=%0d done=%0d want 3 0/10/20 42 1",
                            nbeats, got_v[0], got_v[1], got_v[2], got_x[2], done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_even_step();
        test_single();
        test_reversed();
        test_fractional();
        test_backpressure();
        test_back_to_back();
        test_reset_midspan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
